// File: rtl/step_counter_pkg.sv
// Shared constants for the step counter: overflow-mode codes and bounce direction states.
package step_counter_pkg;

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_SAT    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-count logic: signed step, wrap/saturate/bounce handling, bound pulses.
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned NC = 3,
  parameter int unsigned LO = 0,
  parameter int unsigned HI = (1 << N) - 1
) (
  input  logic [N-1:0]  i_out,
  input  logic [NC-1:0] i_ctrl,
  input  logic [1:0]    i_mode,
  input  logic          i_dir,
  output logic [N-1:0]  o_cnt_c,
  output logic          o_dir_c,
  output logic          o_ovf_c,
  output logic          o_unf_c
);

  localparam int unsigned W    = N + NC + 1;
  localparam int unsigned SPAN = HI - LO + 1;
  localparam logic signed [W-1:0] LO_S   = W'(LO);
  localparam logic signed [W-1:0] HI_S   = W'(HI);
  localparam logic signed [W-1:0] SPAN_S = W'(SPAN);

  // A single wrap correction is only enough if the largest step fits in the range.
  if ((1 << (NC - 1)) > SPAN) begin : g_bad_span
    $error("step_counter_next: count range is narrower than the largest step");
  end
  if (LO >= HI) begin : g_bad_bounds
    $error("step_counter_next: LO must be below HI");
  end

  logic signed [W-1:0] w_s;
  logic signed [W-1:0] w_step;
  logic signed [W-1:0] w_cur;
  logic signed [W-1:0] w_nxt;

  always_comb begin
    w_s    = {{(W-NC){i_ctrl[NC-1]}}, i_ctrl};
    w_step = (i_mode == MODE_BOUNCE && i_dir == DIR_DOWN) ? -w_s : w_s;
    w_cur  = {{(W-N){1'b0}}, i_out};
    w_nxt  = w_cur + w_step;
  end

  always_comb begin
    o_cnt_c = i_out;
    o_dir_c = i_dir;
    o_ovf_c = 1'b0;
    o_unf_c = 1'b0;
    // A zero step never moves the count or raises a pulse.
    if (w_step != '0) begin
      case (i_mode)
        MODE_WRAP: begin
          o_cnt_c = N'(w_nxt);
          if (w_nxt > HI_S) begin
            o_cnt_c = N'(w_nxt - SPAN_S);
            o_ovf_c = 1'b1;
          end else if (w_nxt < LO_S) begin
            o_cnt_c = N'(w_nxt + SPAN_S);
            o_unf_c = 1'b1;
          end
        end
        MODE_SAT: begin
          o_cnt_c = N'(w_nxt);
          if (!w_step[W-1] && w_nxt >= HI_S) begin
            o_cnt_c = N'(HI);
            o_ovf_c = 1'b1;
          end else if (w_step[W-1] && w_nxt <= LO_S) begin
            o_cnt_c = N'(LO);
            o_unf_c = 1'b1;
          end
        end
        MODE_BOUNCE: begin
          o_cnt_c = N'(w_nxt);
          if (!w_step[W-1] && w_nxt >= HI_S) begin
            o_cnt_c = N'(HI);
            o_dir_c = DIR_DOWN;
            o_ovf_c = 1'b1;
          end else if (w_step[W-1] && w_nxt <= LO_S) begin
            o_cnt_c = N'(LO);
            o_dir_c = DIR_UP;
            o_unf_c = 1'b1;
          end
        end
        default: begin
          o_cnt_c = i_out;
        end
      endcase
    end
  end

endmodule

// File: rtl/step_counter.sv
// Parametrised step counter with wrap/saturate/bounce modes, load and bound pulses.
// Optional sticky status flags are built when CNT_STICKY_EN is defined.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned NC = 3,
  parameter int unsigned LO = 0,
  parameter int unsigned HI = (1 << N) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [NC-1:0] ctrl,
  input  logic [1:0]    mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  input  logic          clr,
  output logic [N-1:0]  out,
  output logic          dir,
  output logic          ovf,
  output logic          unf,
  output logic          ovf_sticky,
  output logic          unf_sticky
);

  localparam int unsigned W = N + 1;
  localparam logic signed [W-1:0] LO_S = W'(LO);
  localparam logic signed [W-1:0] HI_S = W'(HI);

  logic [N-1:0] r_out;
  logic         r_dir;
  logic         r_ovf;
  logic         r_unf;

  logic [N-1:0] w_cnt_c;
  logic         w_dir_c;
  logic         w_ovf_c;
  logic         w_unf_c;
  logic [N-1:0] w_out_nxt;
  logic         w_dir_nxt;
  logic         w_ovf_nxt;
  logic         w_unf_nxt;
  logic signed [W-1:0] w_ld_ext;

  step_counter_next #(
    .N  (N),
    .NC (NC),
    .LO (LO),
    .HI (HI)
  ) u_next (
    .i_out   (r_out),
    .i_ctrl  (ctrl),
    .i_mode  (mode),
    .i_dir   (r_dir),
    .o_cnt_c (w_cnt_c),
    .o_dir_c (w_dir_c),
    .o_ovf_c (w_ovf_c),
    .o_unf_c (w_unf_c)
  );

  assign w_ld_ext = {1'b0, load_val};

  // Load beats enable; load clamps into range and only pulses when it had to clamp.
  always_comb begin
    w_out_nxt = r_out;
    w_dir_nxt = r_dir;
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    if (load) begin
      w_out_nxt = load_val;
      if (w_ld_ext > HI_S) begin
        w_out_nxt = N'(HI);
        w_ovf_nxt = 1'b1;
      end else if (w_ld_ext < LO_S) begin
        w_out_nxt = N'(LO);
        w_unf_nxt = 1'b1;
      end
    end else if (en) begin
      w_out_nxt = w_cnt_c;
      w_dir_nxt = w_dir_c;
      w_ovf_nxt = w_ovf_c;
      w_unf_nxt = w_unf_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= N'(LO);
      r_dir <= DIR_UP;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      r_dir <= w_dir_nxt;
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
    end
  end

  assign out = r_out;
  assign dir = r_dir;
  assign ovf = r_ovf;
  assign unf = r_unf;

`ifdef CNT_STICKY_EN
  logic r_ovf_sticky;
  logic r_unf_sticky;

  // A new pulse wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_unf_sticky <= 1'b0;
    end else begin
      r_ovf_sticky <= w_ovf_nxt | (r_ovf_sticky & ~clr);
      r_unf_sticky <= w_unf_nxt | (r_unf_sticky & ~clr);
    end
  end

  assign ovf_sticky = r_ovf_sticky;
  assign unf_sticky = r_unf_sticky;
`else
  logic w_unused;

  assign w_unused   = clr;
  assign ovf_sticky = 1'b0;
  assign unf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_step_counter.sv
// Table-driven scoreboard bench for step_counter (N=4, NC=3, LO=0, HI=15).
module tb_step_counter;

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] ctrl;
    logic [1:0] mode;
    logic       load;
    logic [3:0] lv;
    logic       clr;
    logic [3:0] eo;
    logic       ed;
    logic       eovf;
    logic       eunf;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] out;
    logic       dir;
    logic       ovf;
    logic       unf;
    logic       os;
    logic       us;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] ctrl;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_val;
  logic       clr;
  logic [3:0] out;
  logic       dir;
  logic       ovf;
  logic       unf;
  logic       ovf_sticky;
  logic       unf_sticky;

  int   total = 0;
  int   bad   = 0;
  logic m_os  = 1'b0;
  logic m_us  = 1'b0;
  vec_t tbl[$];
  exp_t sb[$];

  step_counter #(.N(4), .NC(3), .LO(0), .HI(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ctrl       (ctrl),
    .mode       (mode),
    .load       (load),
    .load_val   (load_val),
    .clr        (clr),
    .out        (out),
    .dir        (dir),
    .ovf        (ovf),
    .unf        (unf),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input string nm, input logic e, input logic [2:0] c,
                              input logic [1:0] m, input logic ld, input logic [3:0] lv,
                              input logic cl, input logic [3:0] eo, input logic ed,
                              input logic eovf, input logic eunf);
    vec_t v;
    v.name = nm; v.en = e; v.ctrl = c; v.mode = m; v.load = ld; v.lv = lv; v.clr = cl;
    v.eo = eo; v.ed = ed; v.eovf = eovf; v.eunf = eunf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".out"}, out, e.out);
    chk({e.name, ".dir"}, 4'(dir), 4'(e.dir));
    chk({e.name, ".ovf"}, 4'(ovf), 4'(e.ovf));
    chk({e.name, ".unf"}, 4'(unf), 4'(e.unf));
    chk({e.name, ".ovf_sticky"}, 4'(ovf_sticky), 4'(e.os));
    chk({e.name, ".unf_sticky"}, 4'(unf_sticky), 4'(e.us));
  endtask

  // Drive one vector between edges, queue its expectation, check just after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    en = v.en; ctrl = v.ctrl; mode = v.mode; load = v.load; load_val = v.lv; clr = v.clr;
`ifdef CNT_STICKY_EN
    m_os = v.eovf | (m_os & ~v.clr);
    m_us = v.eunf | (m_us & ~v.clr);
`else
    m_os = 1'b0;
    m_us = 1'b0;
`endif
    e.name = v.name; e.out = v.eo; e.dir = v.ed; e.ovf = v.eovf; e.unf = v.eunf;
    e.os = m_os; e.us = m_us;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ctrl = 3'b000; mode = 2'b00;
    load = 1'b0; load_val = 4'd0; clr = 1'b0;
    #25;
    chk("reset.out", out, 4'd0);
    chk("reset.dir", 4'(dir), 4'd1);
    chk("reset.ovf", 4'(ovf), 4'd0);
    chk("reset.unf", 4'(unf), 4'd0);
    chk("reset.ovf_sticky", 4'(ovf_sticky), 4'd0);
    chk("reset.unf_sticky", 4'(unf_sticky), 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      tbl.push_back(mk("t1_wrap_up", 1'b1, 3'b001, 2'b00, 1'b0, 4'd0, 1'b0,
                       4'((i + 1) % 16), 1'b1, (i == 15), 1'b0));
    tbl.push_back(mk("t2_load1",    1'b0, 3'b000, 2'b00, 1'b1, 4'd1,  1'b0, 4'd1,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("t2_wrap_dn",  1'b1, 3'b110, 2'b00, 1'b0, 4'd0,  1'b0, 4'd15, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk("t2_wrap_dn2", 1'b1, 3'b110, 2'b00, 1'b0, 4'd0,  1'b0, 4'd13, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("t3_load12",   1'b0, 3'b000, 2'b01, 1'b1, 4'd12, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("t3_sat_hi",   1'b1, 3'b011, 2'b01, 1'b0, 4'd0,  1'b0, 4'd15, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("t3_sat_pin",  1'b1, 3'b011, 2'b01, 1'b0, 4'd0,  1'b0, 4'd15, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("t3_sat_dn11", 1'b1, 3'b100, 2'b01, 1'b0, 4'd0,  1'b0, 4'd11, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("t3_sat_dn7",  1'b1, 3'b100, 2'b01, 1'b0, 4'd0,  1'b0, 4'd7,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("t3_sat_dn3",  1'b1, 3'b100, 2'b01, 1'b0, 4'd0,  1'b0, 4'd3,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("t3_sat_lo",   1'b1, 3'b100, 2'b01, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1));
    tbl.push_back(mk("t3_sat_lo2",  1'b1, 3'b100, 2'b01, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1));
    tbl.push_back(mk("t4_load12",   1'b0, 3'b000, 2'b10, 1'b1, 4'd12, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("t4_bnc_hi",   1'b1, 3'b011, 2'b10, 1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("t4_bnc_12",   1'b1, 3'b011, 2'b10, 1'b0, 4'd0,  1'b0, 4'd12, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t4_bnc_9",    1'b1, 3'b011, 2'b10, 1'b0, 4'd0,  1'b0, 4'd9,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t4_bnc_6",    1'b1, 3'b011, 2'b10, 1'b0, 4'd0,  1'b0, 4'd6,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t4_bnc_3",    1'b1, 3'b011, 2'b10, 1'b0, 4'd0,  1'b0, 4'd3,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t4_bnc_lo",   1'b1, 3'b011, 2'b10, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1));
    tbl.push_back(mk("t4_bnc_up3",  1'b1, 3'b011, 2'b10, 1'b0, 4'd0,  1'b0, 4'd3,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("hold_en0",    1'b0, 3'b011, 2'b00, 1'b0, 4'd0,  1'b0, 4'd3,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("mode_hold",   1'b1, 3'b011, 2'b11, 1'b0, 4'd0,  1'b0, 4'd3,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("step0_sat",   1'b1, 3'b000, 2'b01, 1'b0, 4'd0,  1'b0, 4'd3,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("step0_bnc",   1'b1, 3'b000, 2'b10, 1'b0, 4'd0,  1'b0, 4'd3,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("load_and_en", 1'b1, 3'b001, 2'b00, 1'b1, 4'd5,  1'b0, 4'd5,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("bnc_neg_3",   1'b1, 3'b110, 2'b10, 1'b0, 4'd0,  1'b0, 4'd3,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("bnc_neg_1",   1'b1, 3'b110, 2'b10, 1'b0, 4'd0,  1'b0, 4'd1,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("bnc_neg_lo",  1'b1, 3'b110, 2'b10, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk("bnc_up", 1'b1, 3'b011, 2'b10, 1'b0, 4'd0, 1'b0, 4'(3 * i), 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("bnc_up_hi",   1'b1, 3'b011, 2'b10, 1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("bnc_negdn_hi",1'b1, 3'b110, 2'b10, 1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("wrap_dirkeep",1'b1, 3'b001, 2'b00, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("sticky_hold", 1'b0, 3'b001, 2'b00, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("sticky_clr",  1'b0, 3'b001, 2'b00, 1'b0, 4'd0,  1'b1, 4'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("load15",      1'b0, 3'b001, 2'b00, 1'b1, 4'd15, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("clr_and_set", 1'b1, 3'b001, 2'b00, 1'b0, 4'd0,  1'b1, 4'd0,  1'b0, 1'b1, 1'b0));
    for (int i = 1; i <= 9; i++)
      tbl.push_back(mk("count_to_9", 1'b1, 3'b001, 2'b00, 1'b0, 4'd0, 1'b0, 4'(i), 1'b0, 1'b0, 1'b0));

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset pulse between edges, with out=9 and dir=0 beforehand.
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out", out, 4'd0);
    chk("async_rst.dir", 4'(dir), 4'd1);
    chk("async_rst.ovf_sticky", 4'(ovf_sticky), 4'd0);
    #2;
    rst_n = 1'b1;
    m_os = 1'b0;
    m_us = 1'b0;
    apply(mk("resume_1", 1'b1, 3'b001, 2'b00, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0));
    apply(mk("resume_2", 1'b1, 3'b001, 2'b00, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0));

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
